fetch_stage: RTL and testbench

Instruction-fetch stage: owns the PC, runs the instruction-memory read handshake, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the hazard detector and applies its `IF_HD_PC_write` / `IF_ID_HD_write` stall outputs. It also handles EX-stage redirects and data-memory freezes. While an instruction is unavailable, it injects bubbles instead of stalling the rest of the pipeline.

---
 rtl/fetch_stage_pkg.sv | 10 +
 rtl/fetch_stage_if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: FSM state encoding and the NOP used for bubbles.
package rv32i_types;
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, inject a bubble, or hold.
module if_id_reg
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic [width-1:0] pc_d,
  input  logic [width-1:0] instr_d,
  output logic [width-1:0] pc_q,
  output logic [width-1:0] instr_q,
  output logic             valid_q
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= width'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= 1'b1;
    end else if (bubble) begin
      // A bubble keeps the PC so decode still sees where the pipeline stands.
      instr_q <= width'(NOP_INSTR);
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, imem read handshake, IF/ID register.
// Handshake: imem_read_o/imem_address_o stay constant until the one-cycle imem_resp_i strobe.
module fetch_stage
  import rv32i_types::*;
#(
  parameter int                width    = 32,
  parameter logic [width-1:0]  RESET_PC = 32'h00000060
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_HD_PC_write_i,
  input  logic             IF_ID_HD_write_i,
  input  logic             stall_mem_i,
  input  logic             flush_i,
  input  logic [width-1:0] br_target_i,
  output logic             imem_read_o,
  output logic [width-1:0] imem_address_o,
  input  logic [width-1:0] imem_rdata_i,
  input  logic             imem_resp_i,
  output logic [width-1:0] ID_pc_o,
  output logic [width-1:0] ID_instr_o,
  output logic             ID_valid_o,
  output logic [1:0]       state_dbg_o
);
  fetch_state_t     state, state_n;
  logic [width-1:0] pc, pc_n;
  logic [width-1:0] req_addr, req_addr_n;
  logic [width-1:0] buf_q, buf_n;
  logic             id_load, id_bubble;
  logic [width-1:0] id_instr_d;
  logic             adv, ld, fl;

  assign adv = IF_HD_PC_write_i & IF_ID_HD_write_i & ~stall_mem_i;
  assign ld  = IF_ID_HD_write_i & ~stall_mem_i;
  assign fl  = flush_i & ~stall_mem_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_addr <= '0;
      buf_q    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      buf_q    <= buf_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    buf_n      = buf_q;
    id_load    = 1'b0;
    id_bubble  = 1'b0;
    id_instr_d = imem_rdata_i;
    unique case (state)
      FETCH: begin
        if (fl) begin
          pc_n      = br_target_i;
          id_bubble = 1'b1;
          if (!imem_resp_i) begin
            req_addr_n = pc;
            state_n    = DISCARD;
          end
        end else if (imem_resp_i && adv) begin
          id_load = 1'b1;
          pc_n    = pc + width'(4);
        end else if (imem_resp_i) begin
          buf_n     = imem_rdata_i;
          state_n   = HOLD;
          id_bubble = ld;
        end else begin
          id_bubble = ld;
        end
      end
      HOLD: begin
        id_instr_d = buf_q;
        if (fl) begin
          pc_n      = br_target_i;
          id_bubble = 1'b1;
          state_n   = FETCH;
        end else if (adv) begin
          id_load = 1'b1;
          pc_n    = pc + width'(4);
          state_n = FETCH;
        end
      end
      DISCARD: begin
        // The stale response is still owed to req_addr; a new redirect only retargets the PC.
        id_bubble = ld | fl;
        if (fl) pc_n = br_target_i;
        if (imem_resp_i) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    imem_read_o    = 1'b0;
    imem_address_o = pc;
    unique case (state)
      FETCH:   imem_read_o = rst;
      DISCARD: begin
        imem_read_o    = rst;
        imem_address_o = req_addr;
      end
      default: imem_read_o = 1'b0;
    endcase
  end

  assign state_dbg_o = state;

  if_id_reg #(.width(width)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (id_load),
    .bubble  (id_bubble),
    .pc_d    (pc),
    .instr_d (id_instr_d),
    .pc_q    (ID_pc_o),
    .instr_q (ID_instr_o),
    .valid_q (ID_valid_o)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table plus a random-latency streaming scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcw, idw, stall, flush;
  logic [31:0] tgt;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] rdata;
  logic        resp;
  logic [31:0] id_pc, id_instr;
  logic        id_valid;
  logic [1:0]  st_dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .IF_HD_PC_write_i (pcw),
    .IF_ID_HD_write_i (idw),
    .stall_mem_i      (stall),
    .flush_i          (flush),
    .br_target_i      (tgt),
    .imem_read_o      (imem_read),
    .imem_address_o   (imem_addr),
    .imem_rdata_i     (rdata),
    .imem_resp_i      (resp),
    .ID_pc_o          (id_pc),
    .ID_instr_o       (id_instr),
    .ID_valid_o       (id_valid),
    .state_dbg_o      (st_dbg)
  );

  typedef struct {
    logic        pw, iw, st, fl;
    logic [31:0] tg;
    logic        rs;
    logic        x_rd;
    logic [31:0] x_addr;
    logic        x_v;
    logic [31:0] x_pc, x_ins;
    logic [1:0]  x_st;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic row(input logic pw, iw, st, fl, input logic [31:0] tg, input logic rs,
                     input logic x_rd, input logic [31:0] x_addr, input logic x_v,
                     input logic [31:0] x_pc, x_ins, input logic [1:0] x_st);
    vec_t v;
    v.pw = pw; v.iw = iw; v.st = st; v.fl = fl; v.tg = tg; v.rs = rs;
    v.x_rd = x_rd; v.x_addr = x_addr; v.x_v = x_v; v.x_pc = x_pc; v.x_ins = x_ins; v.x_st = x_st;
    tbl.push_back(v);
  endtask

  initial begin
    int          lat;
    logic [31:0] exp_pc;
    logic [63:0] e;
    logic        got_resp;

    rst = 1'b0; pcw = 1'b1; idw = 1'b1; stall = 1'b0; flush = 1'b0;
    tgt = '0; rdata = '0; resp = 1'b0;

    // state encoding: 0 FETCH, 1 HOLD, 2 DISCARD; memory returns instr = address
    row(1,1,0,0, 32'h0,        1, 1, 32'h60,       1, 32'h60,       32'h60,       2'd0);
    row(0,0,0,0, 32'h0,        1, 1, 32'h64,       1, 32'h60,       32'h60,       2'd1);
    row(0,0,0,0, 32'h0,        0, 0, 32'h0,        1, 32'h60,       32'h60,       2'd1);
    row(1,1,0,0, 32'h0,        0, 0, 32'h0,        1, 32'h64,       32'h64,       2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'h68,       1, 32'h68,       32'h68,       2'd0);
    row(1,1,0,0, 32'h0,        0, 1, 32'h6C,       0, 32'h68,       NOP,          2'd0);
    row(1,1,0,0, 32'h0,        0, 1, 32'h6C,       0, 32'h68,       NOP,          2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'h6C,       1, 32'h6C,       32'h6C,       2'd0);
    row(1,1,0,0, 32'h0,        0, 1, 32'h70,       0, 32'h6C,       NOP,          2'd0);
    row(1,1,0,1, 32'h200,      0, 1, 32'h70,       0, 32'h6C,       NOP,          2'd2);
    row(1,1,0,0, 32'h0,        1, 1, 32'h70,       0, 32'h6C,       NOP,          2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'h200,      1, 32'h200,      32'h200,      2'd0);
    row(1,1,1,1, 32'h300,      0, 1, 32'h204,      1, 32'h200,      32'h200,      2'd0);
    row(1,1,1,1, 32'h300,      0, 1, 32'h204,      1, 32'h200,      32'h200,      2'd0);
    row(1,1,0,1, 32'h300,      0, 1, 32'h204,      0, 32'h200,      NOP,          2'd2);
    row(1,1,0,0, 32'h0,        1, 1, 32'h204,      0, 32'h200,      NOP,          2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'h300,      1, 32'h300,      32'h300,      2'd0);
    row(1,1,0,1, 32'h400,      1, 1, 32'h304,      0, 32'h300,      NOP,          2'd0);
    row(1,1,0,0, 32'h0,        0, 1, 32'h400,      0, 32'h300,      NOP,          2'd0);
    row(1,1,0,1, 32'hFFFFFFFC, 1, 1, 32'h400,      0, 32'h300,      NOP,          2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 2'd0);
    row(1,1,0,0, 32'h0,        1, 1, 32'h0,        1, 32'h0,        32'h0,        2'd0);
    row(1,1,0,1, 32'h500,      0, 1, 32'h4,        0, 32'h0,        NOP,          2'd2);

    repeat (2) @(posedge clk);
    #1;
    check("rst_read", 32'(imem_read), 32'h0);
    check("rst_valid", 32'(id_valid), 32'h0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_state", 32'(st_dbg), 32'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      pcw = tbl[i].pw; idw = tbl[i].iw; stall = tbl[i].st; flush = tbl[i].fl;
      tgt = tbl[i].tg; resp = tbl[i].rs; rdata = tbl[i].x_addr;
      #1;
      check($sformatf("row%0d_read", i), 32'(imem_read), 32'(tbl[i].x_rd));
      if (tbl[i].x_rd) check($sformatf("row%0d_addr", i), imem_addr, tbl[i].x_addr);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_valid", i), 32'(id_valid), 32'(tbl[i].x_v));
      check($sformatf("row%0d_pc", i), id_pc, tbl[i].x_pc);
      check($sformatf("row%0d_instr", i), id_instr, tbl[i].x_ins);
      check($sformatf("row%0d_state", i), 32'(st_dbg), 32'(tbl[i].x_st));
    end

    // Reset while in DISCARD with a stale response arriving during reset.
    rst = 1'b0; pcw = 1'b1; idw = 1'b1; stall = 1'b0; flush = 1'b0;
    resp = 1'b1; rdata = 32'h4;
    #1;
    check("disc_rst_read", 32'(imem_read), 32'h0);
    @(posedge clk);
    #1;
    check("disc_rst_state", 32'(st_dbg), 32'h0);
    check("disc_rst_valid", 32'(id_valid), 32'h0);
    check("disc_rst_instr", id_instr, NOP);
    check("disc_rst_pc", id_pc, 32'h0);
    rst = 1'b1; resp = 1'b0;
    #1;
    check("rel_read", 32'(imem_read), 32'h1);
    check("rel_addr", imem_addr, 32'h60);

    // Random-latency stream: each accepted response must show up on ID the next cycle.
    exp_pc = 32'h60;
    for (int n = 0; n < 40; n++) begin
      lat = $urandom_range(0, 3);
      for (int c = 0; c <= lat; c++) begin
        got_resp = (c == lat);
        resp  = got_resp;
        rdata = exp_pc ^ KEY;
        #1;
        check("sb_read", 32'(imem_read), 32'h1);
        check("sb_addr", imem_addr, exp_pc);
        if (got_resp) begin
          exp_q.push_back({exp_pc, exp_pc ^ KEY});
          exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("sb_valid", 32'(id_valid), 32'(got_resp));
        if (id_valid) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", id_pc, e[63:32]);
            check("sb_instr", id_instr, e[31:0]);
          end
        end else begin
          check("sb_bubble_instr", id_instr, NOP);
        end
      end
    end
    resp = 1'b0;
    check("sb_leftover", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
